pic_stream_reader: RTL and testbench

Sequential fetch engine that sits directly upstream of `mem_pic`. It drives `mem_pic`'s `ADDRESS`, captures the combinational `READ` word, and delivers pixels through a small FIFO to downstream logic on a valid/ready stream. A run is defined by a base address, a word count and a fixed address stride. The FIFO absorbs downstream backpressure without losing or repeating words.

---
 rtl/pic_stream_reader.sv | 162 ++++++++++++++++
 tb/tb_pic_stream_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pic_stream_reader.sv
// ---------------------------------------------------------------------------
// pic_stream_reader
//
// Sequential fetch engine placed in front of mem_pic. A run fetches COUNT
// words starting at BASE, stepping the address by STEP each word. Fetched
// words go through a DEPTH-entry FIFO to a valid/ready consumer, so
// downstream backpressure stalls the fetch without losing or repeating words.
//
// Ports
//   CLK        in   clock, all state on the rising edge
//   RESET      in   asynchronous, active-high; clears all state
//   START      in   begin a run (sampled only while idle)
//   BASE       in   first address of the run
//   COUNT      in   number of words to fetch (0 = empty run)
//   ADDRESS    out  registered address to mem_pic
//   READ       in   combinational word from mem_pic at ADDRESS
//   OUT_DATA   out  FIFO head word
//   OUT_VALID  out  FIFO not empty
//   OUT_READY  in   consumer takes OUT_DATA this cycle
//   BUSY       out  run in progress (fetching or draining)
//   DONE       out  one-cycle pulse when a run completes
// ---------------------------------------------------------------------------
module pic_stream_reader #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4,
  parameter int STEP  = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [SIZE-1:0] BASE,
  input  logic [SIZE-1:0] COUNT,
  output logic [SIZE-1:0] ADDRESS,
  input  logic [SIZE-1:0] READ,
  output logic [SIZE-1:0] OUT_DATA,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic            BUSY,
  output logic            DONE
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [SIZE-1:0]   address_q,   address_d;
  logic [SIZE-1:0]   remaining_q, remaining_d;
  logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [OCC_W-1:0]  occ_q,       occ_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic [SIZE-1:0]   fifo_q [DEPTH];

  logic fifo_full;
  logic pop;
  logic push;

  assign fifo_full = (occ_q == OCC_W'(DEPTH));
  assign pop       = (occ_q != '0) && OUT_READY;
  // A pop on the same edge frees the slot, so a full FIFO can still accept
  // a push while the consumer is draining it.
  assign push      = (state_q == S_FETCH) && (remaining_q != '0) &&
                     (!fifo_full || pop);

  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          address_d   = BASE;
          remaining_d = COUNT;
          busy_d      = 1'b1;
          state_d     = (COUNT != '0) ? S_FETCH : S_DRAIN;
        end
      end
      S_FETCH: begin
        if (push) begin
          address_d   = address_q + SIZE'(STEP);
          remaining_d = remaining_q - SIZE'(1);
          if (remaining_q == SIZE'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (occ_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      address_q   <= '0;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      remaining_q <= remaining_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= READ;
      end
    end
  end

  assign ADDRESS   = address_q;
  assign OUT_DATA  = fifo_q[rd_ptr_q];
  assign OUT_VALID = (occ_q != '0);
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_pic_stream_reader.sv
module tb_pic_stream_reader;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [7:0] BASE;
  logic [7:0] COUNT;
  logic [7:0] ADDRESS;
  logic [7:0] READ;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       BUSY;
  logic       DONE;

  int errors = 0;
  int checks = 0;

  pic_stream_reader #(.SIZE(8), .DEPTH(4), .STEP(4)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BASE(BASE), .COUNT(COUNT),
    .ADDRESS(ADDRESS), .READ(READ), .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // mem_pic stand-in: distinct, address-dependent contents.
  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h5A;
  endfunction

  assign READ = mem_f(ADDRESS);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Consume with OUT_READY=1 until DONE; check word order, count, final address.
  task automatic collect(input string nm, input int n, input logic [7:0] base,
                         input logic [7:0] final_addr);
    int got = 0;
    bit done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (OUT_VALID) begin
        if (got < n) chk({nm, "_word"}, OUT_DATA, mem_f(base + 8'(4 * got)));
        got++;
      end
      tick;
      if (DONE) done_seen = 1'b1;
    end
    chk({nm, "_count"}, got, n);
    chk({nm, "_done"}, done_seen, 1);
    chk({nm, "_final_addr"}, ADDRESS, final_addr);
  endtask

  typedef struct {
    logic       start;
    logic [7:0] base;
    logic [7:0] count;
    logic [7:0] e_addr;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] ea, input logic ev, input logic [7:0] ed,
                              input logic eb, input logic edn);
    vec_t v;
    v.start = s; v.base = b; v.count = c;
    v.e_addr = ea; v.e_valid = ev; v.e_data = ed; v.e_busy = eb; v.e_done = edn;
    return v;
  endfunction

  vec_t vecs [13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Basic run BASE=0 COUNT=3, then wraparound run started on the DONE cycle,
    // with an ignored START during its FETCH phase.
    vecs[0]  = mk(1, 8'h00, 8'd3, 8'h00, 0, 8'h00,        1, 0);
    vecs[1]  = mk(0, 8'h00, 8'd0, 8'h04, 1, mem_f(8'h00), 1, 0);
    vecs[2]  = mk(0, 8'h00, 8'd0, 8'h08, 1, mem_f(8'h04), 1, 0);
    vecs[3]  = mk(0, 8'h00, 8'd0, 8'h0C, 1, mem_f(8'h08), 1, 0);
    vecs[4]  = mk(0, 8'h00, 8'd0, 8'h0C, 0, 8'h00,        1, 0);
    vecs[5]  = mk(0, 8'h00, 8'd0, 8'h0C, 0, 8'h00,        0, 1);
    vecs[6]  = mk(1, 8'hF8, 8'd3, 8'hF8, 0, 8'h00,        1, 0);
    vecs[7]  = mk(1, 8'h40, 8'd7, 8'hFC, 1, mem_f(8'hF8), 1, 0);
    vecs[8]  = mk(0, 8'h00, 8'd0, 8'h00, 1, mem_f(8'hFC), 1, 0);
    vecs[9]  = mk(0, 8'h00, 8'd0, 8'h04, 1, mem_f(8'h00), 1, 0);
    vecs[10] = mk(0, 8'h00, 8'd0, 8'h04, 0, 8'h00,        1, 0);
    vecs[11] = mk(0, 8'h00, 8'd0, 8'h04, 0, 8'h00,        0, 1);
    vecs[12] = mk(0, 8'h00, 8'd0, 8'h04, 0, 8'h00,        0, 0);

    RESET = 1'b1; START = 1'b0; BASE = '0; COUNT = '0; OUT_READY = 1'b1;
    #2;
    chk("rst_addr",  ADDRESS, 8'h00);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_busy",  BUSY, 0);
    chk("rst_done",  DONE, 0);
    tick; tick;
    RESET = 1'b0;
    tick;
    chk("rst_remaining", dut.remaining_q, 8'h00);

    for (int i = 0; i < 13; i++) begin
      START = vecs[i].start; BASE = vecs[i].base; COUNT = vecs[i].count;
      tick;
      START = 1'b0;
      chk($sformatf("vec%0d_addr", i),  ADDRESS,   vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), OUT_VALID, vecs[i].e_valid);
      chk($sformatf("vec%0d_busy", i),  BUSY,      vecs[i].e_busy);
      chk($sformatf("vec%0d_done", i),  DONE,      vecs[i].e_done);
      if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), OUT_DATA, vecs[i].e_data);
    end

    // Backpressure: COUNT=6 with consumer stalled.
    OUT_READY = 1'b0;
    START = 1'b1; BASE = 8'h00; COUNT = 8'd6;
    tick;
    START = 1'b0;
    chk("bp_e0_addr", ADDRESS, 8'h00);
    for (int i = 0; i < 4; i++) tick;
    chk("bp_full_addr", ADDRESS, 8'h10);
    chk("bp_full_rem", dut.remaining_q, 8'd2);
    for (int i = 0; i < 3; i++) tick;
    chk("bp_stall_addr", ADDRESS, 8'h10);
    chk("bp_stall_rem", dut.remaining_q, 8'd2);
    chk("bp_stall_valid", OUT_VALID, 1);
    chk("bp_stall_head", OUT_DATA, mem_f(8'h00));
    chk("bp_stall_busy", BUSY, 1);
    OUT_READY = 1'b1;
    collect("bp", 6, 8'h00, 8'h18);

    // Empty run.
    begin
      int done_cnt = 0;
      int first_done = 99;
      bit valid_seen = 1'b0;
      START = 1'b1; BASE = 8'h33; COUNT = 8'd0;
      tick;
      START = 1'b0;
      chk("empty_e0_addr", ADDRESS, 8'h33);
      chk("empty_e0_busy", BUSY, 1);
      chk("empty_e0_valid", OUT_VALID, 0);
      for (int e = 1; e <= 3; e++) begin
        tick;
        if (OUT_VALID) valid_seen = 1'b1;
        if (DONE) begin
          done_cnt++;
          if (first_done == 99) first_done = e;
        end
      end
      chk("empty_done_count", done_cnt, 1);
      chk("empty_done_by_e2", (first_done <= 2), 1);
      chk("empty_no_valid", valid_seen, 0);
      chk("empty_addr", ADDRESS, 8'h33);
      chk("empty_busy_end", BUSY, 0);
    end

    // Reset mid-run after two pushes.
    OUT_READY = 1'b0;
    START = 1'b1; BASE = 8'h00; COUNT = 8'd6;
    tick;
    START = 1'b0;
    tick; tick;
    chk("midrst_pre_addr", ADDRESS, 8'h08);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_addr",  ADDRESS, 8'h00);
    chk("midrst_valid", OUT_VALID, 0);
    chk("midrst_busy",  BUSY, 0);
    chk("midrst_done",  DONE, 0);
    tick;
    chk("midrst_hold_done", DONE, 0);
    RESET = 1'b0;
    OUT_READY = 1'b1;
    START = 1'b1; BASE = 8'h20; COUNT = 8'd1;
    tick;
    START = 1'b0;
    chk("midrst_new_e0_addr", ADDRESS, 8'h20);
    chk("midrst_new_e0_valid", OUT_VALID, 0);
    collect("midrst_new", 1, 8'h20, 8'h24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
